// File: rtl/bft_pkg.sv
// Shared definitions for BFT leaf-side blocks.
//   PKT_W           : packet width
//   *_HI / *_LO     : packet field bit positions
//   bft_pkt_t       : packed view of a packet
//   egress_state_t  : state of the egress output holding register
package bft_pkg;

    localparam int unsigned PKT_W        = 49;
    localparam int unsigned VALID_BIT    = 48;
    localparam int unsigned DEST_LEAF_HI = 47;
    localparam int unsigned DEST_LEAF_LO = 43;
    localparam int unsigned DEST_PORT_HI = 42;
    localparam int unsigned DEST_PORT_LO = 39;
    localparam int unsigned TAG_HI       = 38;
    localparam int unsigned TAG_LO       = 32;
    localparam int unsigned PAYLOAD_HI   = 31;
    localparam int unsigned PAYLOAD_LO   = 0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dest_leaf;
        logic [3:0]  dest_port;
        logic [6:0]  tag;
        logic [31:0] payload;
    } bft_pkt_t;

    typedef enum logic {
        EG_IDLE,
        EG_SEND
    } egress_state_t;

endpackage

// File: rtl/bft_sync_fifo.sv
// Synchronous FIFO, single clock, synchronous active-high reset.
//   push / push_data : write request; taken when not full, or when full
//                      and a pop happens in the same cycle
//   pop / pop_data   : pop request; pop_data shows the head (valid when !empty);
//                      ignored when empty (no write-to-read bypass)
//   full / empty     : occupancy flags
//   level            : number of stored entries, 0..DEPTH
// DEPTH must be a power of 2 and at least 2.
module bft_sync_fifo #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level    = wr_ptr - rd_ptr;
    assign full     = level[AW];
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bft_leaf_endpoint.sv
// BFT-side endpoint of a leaf page.
//   clk, reset               : clock, synchronous active-high reset
//   noc_in_pkt               : packet from the BFT switch
//   din_leaf_bft2interface   : registered copy of noc_in_pkt when addressed here, else 0
//   dout_leaf_interface2bft  : packet from the page into the egress FIFO
//   resend                   : page packet of the previous cycle was refused
//   noc_out_pkt              : egress holding register toward the switch
//   noc_out_resend           : switch refuses the packet presented this cycle
//   ap_start_in / ap_start   : start pulse in, sticky start level out
//   egress_level             : FIFO occupancy (holding register excluded)
//   misroute_cnt / drop_cnt  : saturating status counters
module bft_leaf_endpoint #(
    parameter int unsigned PKT_W      = bft_pkg::PKT_W,
    parameter logic [4:0]  LEAF_ADDR  = 5'd0,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PKT_W-1:0]              noc_in_pkt,
    output logic [PKT_W-1:0]              noc_out_pkt,
    input  logic                          noc_out_resend,
    output logic [PKT_W-1:0]              din_leaf_bft2interface,
    input  logic [PKT_W-1:0]              dout_leaf_interface2bft,
    output logic                          resend,
    input  logic                          ap_start_in,
    output logic                          ap_start,
    output logic [$clog2(FIFO_DEPTH):0]   egress_level,
    output logic [CNT_W-1:0]              misroute_cnt,
    output logic [CNT_W-1:0]              drop_cnt
);

    import bft_pkg::*;

    logic             in_valid;
    logic             in_match;
    logic             page_valid;
    logic             page_accept;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_head;

    egress_state_t    state_q, state_d;
    logic [PKT_W-1:0] out_q, out_d;

    // ---------------- ingress filter ----------------
    assign in_valid = noc_in_pkt[VALID_BIT];
    assign in_match = (noc_in_pkt[DEST_LEAF_HI:DEST_LEAF_LO] == LEAF_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            din_leaf_bft2interface <= '0;
            misroute_cnt           <= '0;
        end else begin
            din_leaf_bft2interface <= (in_valid && in_match) ? noc_in_pkt : '0;
            if (in_valid && !in_match && misroute_cnt != '1)
                misroute_cnt <= misroute_cnt + CNT_W'(1);
        end
    end

    // ---------------- egress FIFO ----------------
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign page_valid  = dout_leaf_interface2bft[VALID_BIT];
    assign page_accept = page_valid && (!fifo_full || fifo_pop);

    bft_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (page_accept),
        .push_data (dout_leaf_interface2bft),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (egress_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resend   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            resend <= page_valid && !page_accept;
            if (page_valid && !page_accept && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // ---------------- egress holding register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EG_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // noc_out_resend only matters while a packet is being presented.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        fifo_pop = 1'b0;
        case (state_q)
            EG_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    out_d    = fifo_head;
                    state_d  = EG_SEND;
                end
            end
            EG_SEND: begin
                if (!noc_out_resend) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        out_d    = fifo_head;
                    end else begin
                        out_d   = '0;
                        state_d = EG_IDLE;
                    end
                end
            end
            default: begin
                out_d   = '0;
                state_d = EG_IDLE;
            end
        endcase
    end

    assign noc_out_pkt = out_q;

    // ---------------- start level ----------------
    always_ff @(posedge clk) begin
        if (reset) ap_start <= 1'b0;
        else if (ap_start_in) ap_start <= 1'b1;
    end

endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Self-checking bench for bft_leaf_endpoint (LEAF_ADDR=3, FIFO_DEPTH=4, CNT_W=4).
module tb_bft_leaf_endpoint;
    import bft_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam logic [4:0]  LEAF  = 5'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] noc_in_pkt, noc_out_pkt, din, dout;
    logic        noc_out_resend, resend, ap_start_in, ap_start;
    logic [2:0]  egress_level;
    logic [CW-1:0] misroute_cnt, drop_cnt;

    always #5 clk = ~clk;

    bft_leaf_endpoint #(
        .PKT_W      (49),
        .LEAF_ADDR  (LEAF),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .noc_in_pkt              (noc_in_pkt),
        .noc_out_pkt             (noc_out_pkt),
        .noc_out_resend          (noc_out_resend),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .ap_start_in             (ap_start_in),
        .ap_start                (ap_start),
        .egress_level            (egress_level),
        .misroute_cnt            (misroute_cnt),
        .drop_cnt                (drop_cnt)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [48:0] mk(input logic [4:0] d, input logic [6:0] tag, input logic [31:0] pl);
        bft_pkt_t p;
        p.valid     = 1'b1;
        p.dest_leaf = d;
        p.dest_port = 4'd2;
        p.tag       = tag;
        p.payload   = pl;
        return p;
    endfunction

    // ---------------- behavioural model ----------------
    logic [48:0] m_q[$];
    bit          m_out_v;
    logic [48:0] m_out, m_din;
    bit          m_resend, m_ap;
    int          m_mis, m_drop;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_out_v  = 0;
            m_out    = '0;
            m_din    = '0;
            m_resend = 0;
            m_ap     = 0;
            m_mis    = 0;
            m_drop   = 0;
        end else begin
            m_din = (noc_in_pkt[48] && noc_in_pkt[47:43] == LEAF) ? noc_in_pkt : '0;
            if (noc_in_pkt[48] && noc_in_pkt[47:43] != LEAF && m_mis < CMAX) m_mis++;
            // Outgoing slot is free (or just delivered): refill from the queue head
            // as it stood before this cycle's write.
            if (!m_out_v || !noc_out_resend) begin
                if (m_q.size() > 0) begin
                    m_out   = m_q.pop_front();
                    m_out_v = 1;
                end else begin
                    m_out   = '0;
                    m_out_v = 0;
                end
            end
            m_resend = 0;
            if (dout[48]) begin
                if (m_q.size() < DEPTH) m_q.push_back(dout);
                else begin
                    m_resend = 1;
                    if (m_drop < CMAX) m_drop++;
                end
            end
            m_ap = m_ap | ap_start_in;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("din",          din,          m_din);
            chk("noc_out",      noc_out_pkt,  m_out_v ? m_out : 49'd0);
            chk("resend",       resend,       m_resend);
            chk("ap_start",     ap_start,     m_ap);
            chk("egress_level", egress_level, m_q.size());
            chk("misroute_cnt", misroute_cnt, m_mis);
            chk("drop_cnt",     drop_cnt,     m_drop);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [48:0] ps[8];
    logic [48:0] a;

    initial begin
        reset = 1; noc_in_pkt = '0; dout = '0; noc_out_resend = 0; ap_start_in = 0;
        tick();
        check_en = 1;
        tick();
        chk("rst_noc_out", noc_out_pkt, 0);
        chk("rst_din", din, 0);
        chk("rst_level", egress_level, 0);
        chk("rst_ap", ap_start, 0);
        reset = 0;

        // ingress filter
        noc_in_pkt = mk(5'd3, 7'h01, 32'hA5A5A5A5);
        tick();
        chk("ing_match", din, 49'h11901A5A5A5A5);
        noc_in_pkt = mk(5'd4, 7'h02, 32'h12345678);
        tick();
        chk("ing_miss_din", din, 0);
        chk("ing_misroute", misroute_cnt, 1);
        noc_in_pkt = '0;

        // streaming of 5 packets
        for (int i = 0; i < 5; i++) ps[i] = mk(5'd9, 7'(i + 1), $urandom);
        for (int i = 0; i < 5; i++) begin
            dout = ps[i];
            tick();
            if (i >= 1) chk("stream_out", noc_out_pkt, ps[i-1]);
            chk("stream_resend", resend, 0);
        end
        dout = '0;
        tick();
        chk("stream_last", noc_out_pkt, ps[4]);
        chk("stream_level", egress_level, 0);
        tick();
        chk("stream_idle", noc_out_pkt, 0);

        // switch back-pressure
        ps[0] = mk(5'd1, 7'h11, $urandom);
        ps[1] = mk(5'd1, 7'h22, $urandom);
        dout = ps[0]; tick();
        dout = ps[1]; tick();
        chk("bp_first", noc_out_pkt, ps[0]);
        dout = '0; noc_out_resend = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", noc_out_pkt, ps[0]);
        end
        noc_out_resend = 0;
        tick();
        chk("bp_next", noc_out_pkt, ps[1]);
        tick();
        chk("bp_idle", noc_out_pkt, 0);

        // full FIFO with constant back-pressure
        noc_out_resend = 1;
        for (int i = 0; i < 7; i++) ps[i] = mk(5'd2, 7'(8'h30 + i), $urandom);
        for (int i = 0; i < 7; i++) begin
            dout = ps[i];
            tick();
            if (i >= 5) chk("full_resend", resend, 1);
            else chk("full_noresend", resend, 0);
        end
        chk("full_drop", drop_cnt, 2);
        chk("full_level", egress_level, 4);
        chk("full_out", noc_out_pkt, ps[0]);
        dout = '0;
        tick();
        chk("full_resend_clr", resend, 0);

        // simultaneous push/pop on full
        ps[7] = mk(5'd2, 7'h3F, $urandom);
        noc_out_resend = 0; dout = ps[7];
        tick();
        chk("pp_resend", resend, 0);
        chk("pp_level", egress_level, 4);
        chk("pp_out", noc_out_pkt, ps[1]);
        dout = '0;
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("drain", noc_out_pkt, ps[i]);
        end
        tick();
        chk("drain_pp", noc_out_pkt, ps[7]);
        tick();
        chk("drain_idle", noc_out_pkt, 0);

        // drop counter saturation
        noc_out_resend = 1;
        for (int i = 0; i < 25; i++) begin
            dout = mk(5'd5, 7'(i), $urandom);
            tick();
        end
        chk("sat_drop", drop_cnt, 4'hF);
        dout = '0;
        tick();

        // reset mid-operation
        reset = 1; tick(); reset = 0;
        ap_start_in = 1; tick(); ap_start_in = 0;
        chk("ap_rise", ap_start, 1);
        tick();
        chk("ap_hold", ap_start, 1);
        noc_out_resend = 1;
        a = mk(5'd6, 7'h40, $urandom);
        dout = a; tick();
        for (int i = 0; i < 3; i++) begin
            dout = mk(5'd6, 7'(8'h41 + i), $urandom);
            tick();
        end
        dout = '0;
        chk("pre_rst_level", egress_level, 3);
        chk("pre_rst_out", noc_out_pkt, a);
        reset = 1; tick();
        chk("rst_out", noc_out_pkt, 0);
        chk("rst_level2", egress_level, 0);
        chk("rst_ap2", ap_start, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 0; noc_out_resend = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_out", noc_out_pkt, 0);
        end

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int unsigned bp;
            bp = ((c / 200) % 3 == 0) ? 0 : (((c / 200) % 3 == 1) ? 30 : 85);
            noc_in_pkt = ($urandom_range(99) < 60)
                ? mk(($urandom_range(1) == 1) ? LEAF : 5'($urandom), 7'($urandom), $urandom) : 49'd0;
            dout = ($urandom_range(99) < 70) ? mk(5'($urandom), 7'($urandom), $urandom)
                                              : {1'b0, 48'($urandom)};
            noc_out_resend = ($urandom_range(99) < bp);
            ap_start_in    = ($urandom_range(299) == 0);
            reset          = ($urandom_range(699) == 0);
            tick();
        end
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
